// File: rtl/snitch_data_mem_bist_if.sv
// snitch_data_mem_bist_if: per-bank TCDM request/response bundle (cs/add/wen/be/wdata, 1-cycle rdata)
interface snitch_data_mem_bist_if #(
    parameter int unsigned NumTotalBanks   = 32,
    parameter int unsigned AddrWidth       = 10,
    parameter int unsigned NarrowDataWidth = 64
);
    logic [NumTotalBanks-1:0]                        cs;
    logic [NumTotalBanks-1:0][AddrWidth-1:0]         add;
    logic [NumTotalBanks-1:0]                        wen;
    logic [NumTotalBanks-1:0][NarrowDataWidth/8-1:0] be;
    logic [NumTotalBanks-1:0][NarrowDataWidth-1:0]   wdata;
    logic [NumTotalBanks-1:0][NarrowDataWidth-1:0]   rdata;

    modport master (output cs, add, wen, be, wdata, input rdata);
    modport slave  (input cs, add, wen, be, wdata, output rdata);
endinterface

// File: rtl/snitch_data_mem_bist.sv
// snitch_data_mem_bist: March C- self-test over all TCDM banks in lockstep.
// Requests are registered one cycle behind the FSM state; read data is compared one cycle after each read.
module snitch_data_mem_bist #(
    parameter int unsigned TCDMDepth       = 1024,
    parameter int unsigned NarrowDataWidth = 64,
    parameter int unsigned NumTotalBanks   = 32,
    parameter int unsigned AddrWidth       = $clog2(TCDMDepth),
    parameter int unsigned BankIdxWidth    = $clog2(NumTotalBanks)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      fail_o,
    output logic [NumTotalBanks-1:0]  err_mask_o,
    output logic [BankIdxWidth-1:0]   fail_bank_o,
    output logic [AddrWidth-1:0]      fail_addr_o,
    snitch_data_mem_bist_if.master    mem
);
    typedef enum logic [3:0] {IDLE, M0, M1, M2, M3, M4, M5, FINAL, DONE} state_e;

    state_e                    state_q, state_d;
    logic [AddrWidth-1:0]      addr_q, addr_d;
    logic                      phase_q, phase_d;
    logic                      cs_q, cs_d, wen_q, wen_d, pat_q, pat_d;
    logic [AddrWidth-1:0]      add_q, add_d;
    logic                      cmp_valid_q, cmp_valid_d, exp_q, exp_d;
    logic [AddrWidth-1:0]      cmp_addr_q, cmp_addr_d;
    logic                      busy_q, busy_d, done_q, done_d, fail_q, fail_d;
    logic [NumTotalBanks-1:0]  err_mask_q, err_mask_d;
    logic [BankIdxWidth-1:0]   fail_bank_q, fail_bank_d;
    logic [AddrWidth-1:0]      fail_addr_q, fail_addr_d;
    logic                      active, paired, down, req_wen, req_pat, at_end, step, start_ok;
    logic [NumTotalBanks-1:0]  mis;
    logic [BankIdxWidth-1:0]   first_bank;

    always_comb begin
        active   = state_q inside {M0, M1, M2, M3, M4, M5};
        paired   = state_q inside {M1, M2, M3, M4};
        down     = state_q inside {M3, M4};
        req_wen  = (state_q == M0) || (paired && phase_q);
        req_pat  = (state_q inside {M1, M3}) ? phase_q : (state_q inside {M2, M4}) ? ~phase_q : 1'b0;
        at_end   = down ? (addr_q == '0) : (addr_q == '1);
        step     = !paired || phase_q;
        start_ok = start_i && (state_q == IDLE || (state_q == DONE && done_q));
        state_d  = state_q;
        addr_d   = addr_q;
        phase_d  = phase_q;
        if (start_ok) begin
            state_d = M0;
            addr_d  = '0;
            phase_d = 1'b0;
        end else if (active) begin
            phase_d = paired && !phase_q;
            if (step && at_end) begin
                state_d = state_e'(state_q + 4'd1);
                addr_d  = (state_q inside {M2, M3}) ? '1 : '0;
            end else if (step) begin
                addr_d = down ? addr_q - AddrWidth'(1) : addr_q + AddrWidth'(1);
            end
        end else if (state_q == FINAL) begin
            state_d = DONE;
        end
        cs_d        = active;
        wen_d       = active && req_wen;
        pat_d       = active && req_pat;
        add_d       = active ? addr_q : '0;
        busy_d      = active || state_q == FINAL;
        done_d      = state_q == DONE;
        cmp_valid_d = cs_q && !wen_q;
        exp_d       = pat_q;
        cmp_addr_d  = add_q;
        mis = '0;
        for (int b = 0; b < NumTotalBanks; b++)
            mis[b] = cmp_valid_q && (mem.rdata[b] != {NarrowDataWidth{exp_q}});
        first_bank = '0;
        for (int b = NumTotalBanks - 1; b >= 0; b--)
            if (mis[b]) first_bank = BankIdxWidth'(b);
        // A new run wipes results; otherwise only the first failing cycle latches bank/address.
        err_mask_d  = start_ok ? '0 : err_mask_q | mis;
        fail_d      = !start_ok && (fail_q || |mis);
        fail_bank_d = start_ok ? '0 : (|mis && !fail_q) ? first_bank : fail_bank_q;
        fail_addr_d = start_ok ? '0 : (|mis && !fail_q) ? cmp_addr_q : fail_addr_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            phase_q     <= 1'b0;
            cs_q        <= 1'b0;
            wen_q       <= 1'b0;
            pat_q       <= 1'b0;
            add_q       <= '0;
            cmp_valid_q <= 1'b0;
            exp_q       <= 1'b0;
            cmp_addr_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            err_mask_q  <= '0;
            fail_bank_q <= '0;
            fail_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            phase_q     <= phase_d;
            cs_q        <= cs_d;
            wen_q       <= wen_d;
            pat_q       <= pat_d;
            add_q       <= add_d;
            cmp_valid_q <= cmp_valid_d;
            exp_q       <= exp_d;
            cmp_addr_q  <= cmp_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
            err_mask_q  <= err_mask_d;
            fail_bank_q <= fail_bank_d;
            fail_addr_q <= fail_addr_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign fail_o      = fail_q;
    assign err_mask_o  = err_mask_q;
    assign fail_bank_o = fail_bank_q;
    assign fail_addr_o = fail_addr_q;
    assign mem.cs      = {NumTotalBanks{cs_q}};
    assign mem.wen     = {NumTotalBanks{wen_q}};
    assign mem.add     = {NumTotalBanks{add_q}};
    assign mem.be      = {(NumTotalBanks * NarrowDataWidth / 8){cs_q}};
    assign mem.wdata   = {(NumTotalBanks * NarrowDataWidth){wen_q && pat_q}};
endmodule

// File: tb/tb_snitch_data_mem_bist.sv
// tb_snitch_data_mem_bist: March C- run checks against a faultable bank-array model with request/result scoreboards.
module tb_snitch_data_mem_bist;
    localparam int D  = 16;
    localparam int NB = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_i, start_i;
    logic busy_o, done_o, fail_o;
    logic [NB-1:0] err_mask_o;
    logic [1:0]    fail_bank_o;
    logic [3:0]    fail_addr_o;

    snitch_data_mem_bist_if #(.NumTotalBanks(NB), .AddrWidth(4), .NarrowDataWidth(DW)) mem_if ();

    snitch_data_mem_bist #(.TCDMDepth(D), .NarrowDataWidth(DW), .NumTotalBanks(NB)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
        .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o),
        .err_mask_o(err_mask_o), .fail_bank_o(fail_bank_o), .fail_addr_o(fail_addr_o),
        .mem(mem_if)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] marr [NB][D];
    logic [DW-1:0] sa1 [NB][D];
    logic [NB-1:0][DW-1:0] rdata_r;
    logic dec_fault;

    // Bank model: sa1 forces bits high on read; dec_fault makes bank 0 addr 3 writes also land on addr 7.
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (mem_if.cs[b]) begin
                if (mem_if.wen[b]) begin
                    marr[b][mem_if.add[b]] <= mem_if.wdata[b];
                    if (dec_fault && b == 0 && mem_if.add[b] == 4'd3) marr[0][7] <= mem_if.wdata[b];
                end else begin
                    rdata_r[b] <= marr[b][mem_if.add[b]] | sa1[b][mem_if.add[b]];
                end
            end
        end
    end
    assign mem_if.rdata = rdata_r;

    int n_checks = 0;
    int n_errors = 0;
    logic [59:0] req_q [$];
    logic [10:0] res_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [59:0] req_sig(input logic w, input int a, input logic p);
        logic [3:0] a4;
        a4 = 4'(a);
        return {4'hf, {4{w}}, {4{a4}}, 4'hf, (w ? {32{p}} : 32'h0)};
    endfunction

    task automatic push_march();
        for (int a = 0; a < D; a++) req_q.push_back(req_sig(1, a, 0));
        for (int a = 0; a < D; a++) begin req_q.push_back(req_sig(0, a, 0)); req_q.push_back(req_sig(1, a, 1)); end
        for (int a = 0; a < D; a++) begin req_q.push_back(req_sig(0, a, 1)); req_q.push_back(req_sig(1, a, 0)); end
        for (int a = D - 1; a >= 0; a--) begin req_q.push_back(req_sig(0, a, 0)); req_q.push_back(req_sig(1, a, 1)); end
        for (int a = D - 1; a >= 0; a--) begin req_q.push_back(req_sig(0, a, 1)); req_q.push_back(req_sig(1, a, 0)); end
        for (int a = 0; a < D; a++) req_q.push_back(req_sig(0, a, 0));
    endtask

    task automatic clear_faults();
        for (int b = 0; b < NB; b++)
            for (int a = 0; a < D; a++) begin
                sa1[b][a]  = '0;
                marr[b][a] = '0;
            end
        dec_fault = 1'b0;
    endtask

    task automatic monitor_req();
        logic [59:0] e;
        if (mem_if.cs[0]) begin
            if (req_q.size() == 0) check("req_extra", 64'(mem_if.add[0]), 64'hffff);
            else begin
                e = req_q.pop_front();
                check("req", 64'({mem_if.cs, mem_if.wen, mem_if.add, mem_if.be, mem_if.wdata}), 64'(e));
            end
        end
    endtask

    // Drives one full run from a negedge; expected result is queued at start and compared when done rises.
    task automatic run(input logic ef, input logic [3:0] em, input logic [1:0] eb, input logic [3:0] ea,
                       input bit pulses);
        int done_at, busy_cnt;
        logic [10:0] r;
        res_q.push_back({ef, em, eb, ea});
        push_march();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        done_at = 0;
        busy_cnt = 0;
        for (int k = 1; k <= 400 && done_at == 0; k++) begin
            @(negedge clk);
            start_i = pulses && (k == 10 || k == 100);
            if (k == 1) begin
                check("start_busy", 64'(busy_o), 64'd1);
                check("start_done_clr", 64'(done_o), 64'd0);
                check("start_res_clr", 64'({fail_o, err_mask_o, fail_bank_o, fail_addr_o}), 64'd0);
            end
            if (busy_o) busy_cnt++;
            monitor_req();
            if (done_o) done_at = k;
        end
        start_i = 1'b0;
        check("done_edge", 64'(done_at), 64'd162);
        check("busy_cycles", 64'(busy_cnt), 64'd161);
        check("req_left", 64'(req_q.size()), 64'd0);
        check("busy_end", 64'(busy_o), 64'd0);
        r = res_q.pop_front();
        check("fail", 64'(fail_o), 64'(r[10]));
        check("err_mask", 64'(err_mask_o), 64'(r[9:6]));
        check("fail_bank", 64'(fail_bank_o), 64'(r[5:4]));
        check("fail_addr", 64'(fail_addr_o), 64'(r[3:0]));
        req_q.delete();
    endtask

    task automatic check_idle(input string tag);
        check(tag, 64'({busy_o, done_o, fail_o, err_mask_o, fail_bank_o, fail_addr_o}), 64'd0);
        check({tag, "_mem"}, 64'({mem_if.cs, mem_if.wen, mem_if.add, mem_if.be, mem_if.wdata}), 64'd0);
    endtask

    initial begin
        rst_i = 1'b1;
        start_i = 1'b0;
        rdata_r = '0;
        clear_faults();
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        check_idle("reset");
        run(1'b0, 4'b0000, 2'd0, 4'd0, 1'b1);
        clear_faults();
        sa1[2][5] = 8'h01;
        run(1'b1, 4'b0100, 2'd2, 4'd5, 1'b0);
        clear_faults();
        run(1'b0, 4'b0000, 2'd0, 4'd0, 1'b0);
        clear_faults();
        sa1[3][9] = 8'h01;
        sa1[1][9] = 8'h01;
        run(1'b1, 4'b1010, 2'd1, 4'd9, 1'b0);
        clear_faults();
        dec_fault = 1'b1;
        run(1'b1, 4'b0001, 2'd0, 4'd7, 1'b0);
        clear_faults();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (40) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        check_idle("mid_reset");
        rst_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_reset_cs", 64'({mem_if.cs, busy_o}), 64'd0);
        end
        run(1'b0, 4'b0000, 2'd0, 4'd0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
